hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage ARM pipeline (F/D/E/M/W).
- Consumes the register-match vector and branch outcome produced by the datapath, plus decode-stage control bits from the controller.
- Internally pipelines those control bits D→E→M→W and drives forwarding selects, stalls and flushes back into the datapath.
- Keeps saturating performance counters for load-use stalls and branch flushes.

Parameters:
- CNT_W, 16, width of each saturating performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- match  in  5  {match_1e_m, match_2e_m, match_1e_w, match_2e_w, match_12d_e} from datapath register-address comparators.
- RegWriteD  in  1  decoded instruction in D writes a register (unconditioned).
- MemtoRegD  in  1  decoded instruction in D is a load.
- PCSrcD  in  1  decoded instruction in D writes R15 (unconditioned).
- CondExE  in  1  condition check passed for instruction in E.
- BranchTakenE  in  1  branch in E resolved taken.
- ForwardAE  out  2  SrcA select: 00 RD1E, 01 ResultW, 10 ALUOutM.
- ForwardBE  out  2  WriteDataE select, same encoding.
- StallF  out  1  hold PC register.
- StallD  out  1  hold D pipeline register.
- FlushD  out  1  clear D pipeline register.
- FlushE  out  1  clear E pipeline register.
- ldstall_cnt  out  CNT_W  cycles spent in load-use stall.
- brflush_cnt  out  CNT_W  cycles with BranchTakenE asserted.

Behaviour:
- Internal state, all cleared to 0 by reset, updated on rising clk:
  - E regs: RegWriteE, MemtoRegE, PCSrcE.
  - M regs: RegWriteM, PCSrcM.
  - W regs: RegWriteW, PCSrcW.
- Qualification at E: RegWriteEq = RegWriteE & CondExE; PCSrcEq = PCSrcE & CondExE.
- D→E transfer: E regs load {RegWriteD, MemtoRegD, PCSrcD}, or all zero when FlushE is 1 in that cycle.
- E→M transfer: M regs load {RegWriteEq, PCSrcEq} unconditionally. M→W: W regs load M regs unconditionally.
- Forwarding (combinational from state and match):
  - ForwardAE = 10 if match[4] & RegWriteM; else 01 if match[2] & RegWriteW; else 00. M has priority when both match.
  - ForwardBE uses the same rule with match[3] and match[1].
- Load-use stall: ldrstall = match[0] & MemtoRegE & RegWriteE. Deliberately unqualified by CondExE (conservative).
- PC write pending: PCWrPendingF = PCSrcD | PCSrcE | PCSrcM.
- Stall/flush outputs:
  - StallF = ldrstall | PCWrPendingF.
  - StallD = ldrstall.
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenE.
  - FlushE = ldrstall | BranchTakenE.
- Simultaneous ldrstall and BranchTakenE: FlushE=1, StallD=1, FlushD=1. Flush dominates; the E bubble is inserted once.
- All outputs are combinational of current state and inputs; zero added latency. A load-use stall lasts exactly 1 cycle, because the bubble clears MemtoRegE.
- Counters:
  - ldstall_cnt increments on each cycle with ldrstall=1; brflush_cnt on each cycle with BranchTakenE=1.
  - Both saturate at 2^CNT_W−1 with no wrap.
- Reset values:
  - All internal regs and counters are 0.
  - Outputs: ForwardAE=ForwardBE=00, StallF = PCSrcD, StallD=0, FlushD = PCSrcD | BranchTakenE, FlushE = BranchTakenE.
  - Reset asserted mid-stall clears state immediately (asynchronous), so the stall drops the same cycle.

Test Plan:
- Reset with all inputs 0, then idle 3 cycles → all outputs 0, both counters 0.
- ADD R1 (RegWriteD=1, CondExE=1), next cycle match=5'b10000 → ForwardAE=10. One cycle later match=5'b00100 → ForwardAE=01. Both match[4] and match[2] with RegWriteM=RegWriteW=1 → ForwardAE=10.
- Load (RegWriteD=1, MemtoRegD=1) into E, match[0]=1 → StallF=StallD=FlushE=1 for exactly 1 cycle, ldstall_cnt=1. Next cycle stall clear and ForwardAE/BE=10 on the matching operand.
- Conditional write failing (RegWriteD=1, CondExE=0), then match=5'b11000 → ForwardAE=ForwardBE=00.
- PCSrcD=1 held 1 cycle → StallF=1 for 3 cycles (D, E, M) with FlushD=1 for 4 cycles (D..W). Same with BranchTakenE=1 in the same E cycle → FlushE=1 and brflush_cnt=1.
- CNT_W=2, force 5 load-use stalls → ldstall_cnt stops at 3. Assert reset mid-stall → counters 0 and StallD=0 immediately.

Source files
------------

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage pipeline: forwarding, stalls, flushes.
// In: match vector, D-stage controls, CondExE, BranchTakenE. Out: Forward*, Stall*, Flush*, perf counters.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       match,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             PCSrcD,
  input  logic             CondExE,
  input  logic             BranchTakenE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] ldstall_cnt,
  output logic [CNT_W-1:0] brflush_cnt
);

  logic reg_write_e, memto_reg_e, pcsrc_e;
  logic reg_write_m, pcsrc_m;
  logic reg_write_w, pcsrc_w;
  logic reg_write_eq, pcsrc_eq;
  logic ldrstall, pc_wr_pending;

  assign reg_write_eq = reg_write_e & CondExE;
  assign pcsrc_eq     = pcsrc_e & CondExE;

  // Load-use check ignores CondExE on purpose: stalling is always safe.
  assign ldrstall      = match[0] & memto_reg_e & reg_write_e;
  assign pc_wr_pending = PCSrcD | pcsrc_e | pcsrc_m;

  assign StallF = ldrstall | pc_wr_pending;
  assign StallD = ldrstall;
  assign FlushD = pc_wr_pending | pcsrc_w | BranchTakenE;
  assign FlushE = ldrstall | BranchTakenE;

  // M has priority over W: it holds the younger result.
  always_comb begin
    ForwardAE = 2'b00;
    if (match[4] & reg_write_m)
      ForwardAE = 2'b10;
    else if (match[2] & reg_write_w)
      ForwardAE = 2'b01;
  end

  always_comb begin
    ForwardBE = 2'b00;
    if (match[3] & reg_write_m)
      ForwardBE = 2'b10;
    else if (match[1] & reg_write_w)
      ForwardBE = 2'b01;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_e <= 1'b0;
      memto_reg_e <= 1'b0;
      pcsrc_e     <= 1'b0;
      reg_write_m <= 1'b0;
      pcsrc_m     <= 1'b0;
      reg_write_w <= 1'b0;
      pcsrc_w     <= 1'b0;
    end else begin
      if (FlushE) begin
        reg_write_e <= 1'b0;
        memto_reg_e <= 1'b0;
        pcsrc_e     <= 1'b0;
      end else begin
        reg_write_e <= RegWriteD;
        memto_reg_e <= MemtoRegD;
        pcsrc_e     <= PCSrcD;
      end
      reg_write_m <= reg_write_eq;
      pcsrc_m     <= pcsrc_eq;
      reg_write_w <= reg_write_m;
      pcsrc_w     <= pcsrc_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ldstall_cnt <= '0;
      brflush_cnt <= '0;
    end else begin
      if (ldrstall && (ldstall_cnt != '1))
        ldstall_cnt <= ldstall_cnt + CNT_W'(1);
      if (BranchTakenE && (brflush_cnt != '1))
        brflush_cnt <= brflush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding, load-use, PC/branch flushes, counters.
// Second instance with CNT_W=2 checks counter saturation.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] match;
  logic       RegWriteD, MemtoRegD, PCSrcD, CondExE, BranchTakenE;

  logic [1:0]  fa, fb, fa2, fb2;
  logic        sf, sd, fd, fe, sf2, sd2, fd2, fe2;
  logic [15:0] ld_cnt, br_cnt;
  logic [1:0]  ld_cnt2, br_cnt2;

  int vecs = 0;
  int errs = 0;
  int exp_ld = 0;

  always #5 clk = ~clk;

  hazard_unit #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .match(match),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
    .PCSrcD(PCSrcD), .CondExE(CondExE),
    .BranchTakenE(BranchTakenE),
    .ForwardAE(fa), .ForwardBE(fb),
    .StallF(sf), .StallD(sd), .FlushD(fd), .FlushE(fe),
    .ldstall_cnt(ld_cnt), .brflush_cnt(br_cnt)
  );

  hazard_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .match(match),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
    .PCSrcD(PCSrcD), .CondExE(CondExE),
    .BranchTakenE(BranchTakenE),
    .ForwardAE(fa2), .ForwardBE(fb2),
    .StallF(sf2), .StallD(sd2), .FlushD(fd2), .FlushE(fe2),
    .ldstall_cnt(ld_cnt2), .brflush_cnt(br_cnt2)
  );

  task automatic chk(input string tag, input int got, input int exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drv(input logic rw, input logic mr,
                     input logic pc, input logic ce,
                     input logic bt, input logic [4:0] m);
    RegWriteD = rw; MemtoRegD = mr; PCSrcD = pc;
    CondExE = ce; BranchTakenE = bt; match = m;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sfde(input string tag, input int f,
                      input int d, input int fdv, input int fev);
    chk({tag, ".StallF"}, int'(sf), f);
    chk({tag, ".StallD"}, int'(sd), d);
    chk({tag, ".FlushD"}, int'(fd), fdv);
    chk({tag, ".FlushE"}, int'(fe), fev);
  endtask

  task automatic idle(input int n);
    drv(0, 0, 0, 0, 0, 5'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 5'b0);
    sfde("rst_idle", 0, 0, 0, 0);
    chk("rst_fa", int'(fa), 0);
    drv(0, 0, 1, 0, 1, 5'b11111);
    sfde("rst_pcsrc_bt", 1, 0, 1, 1);
    chk("rst_fa_m", int'(fa), 0);
    chk("rst_fb_m", int'(fb), 0);
    drv(0, 0, 0, 0, 0, 5'b0);
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    sfde("idle", 0, 0, 0, 0);
    chk("idle_fa", int'(fa), 0);
    chk("idle_fb", int'(fb), 0);
    chk("idle_ldcnt", int'(ld_cnt), 0);
    chk("idle_brcnt", int'(br_cnt), 0);

    // ADD in D, then E, M, W
    drv(1, 0, 0, 1, 0, 5'b0); tick();
    drv(0, 0, 0, 1, 0, 5'b10000);
    chk("fwd_e_not_yet", int'(fa), 0);
    tick();
    drv(0, 0, 0, 1, 0, 5'b10000);
    chk("fwd_m_a", int'(fa), 2);
    drv(0, 0, 0, 1, 0, 5'b01000);
    chk("fwd_m_b", int'(fb), 2);
    tick();
    drv(0, 0, 0, 1, 0, 5'b00100);
    chk("fwd_w_a", int'(fa), 1);
    drv(0, 0, 0, 1, 0, 5'b00010);
    chk("fwd_w_b", int'(fb), 1);
    drv(0, 0, 0, 1, 0, 5'b10000);
    chk("fwd_w_m_nomatch", int'(fa), 0);
    idle(3);

    // two back-to-back writers: M and W both valid
    drv(1, 0, 0, 1, 0, 5'b0); tick();
    drv(1, 0, 0, 1, 0, 5'b0); tick();
    drv(0, 0, 0, 1, 0, 5'b0); tick();
    drv(0, 0, 0, 1, 0, 5'b10100);
    chk("fwd_prio_a", int'(fa), 2);
    drv(0, 0, 0, 1, 0, 5'b01010);
    chk("fwd_prio_b", int'(fb), 2);
    drv(0, 0, 0, 1, 0, 5'b00100);
    chk("fwd_w_only_a", int'(fa), 1);
    idle(3);

    // load-use
    drv(1, 1, 0, 1, 0, 5'b0); tick();
    drv(0, 0, 0, 1, 0, 5'b00001);
    sfde("lduse", 1, 1, 0, 1);
    tick(); exp_ld++;
    drv(0, 0, 0, 1, 0, 5'b00001);
    sfde("lduse_clear", 0, 0, 0, 0);
    chk("lduse_cnt", int'(ld_cnt), exp_ld);
    drv(0, 0, 0, 1, 0, 5'b11000);
    chk("lduse_fwd_a", int'(fa), 2);
    chk("lduse_fwd_b", int'(fb), 2);
    idle(3);

    // conditional writer that fails its condition
    drv(1, 0, 0, 1, 0, 5'b0); tick();
    drv(0, 0, 0, 0, 0, 5'b0); tick();
    drv(0, 0, 0, 1, 0, 5'b11000);
    chk("cond_fail_a", int'(fa), 0);
    chk("cond_fail_b", int'(fb), 0);
    tick();
    drv(0, 0, 0, 1, 0, 5'b00110);
    chk("cond_fail_wa", int'(fa), 0);
    chk("cond_fail_wb", int'(fb), 0);
    idle(3);

    // PC write travels D, E, M, W
    drv(0, 0, 1, 1, 0, 5'b0);
    sfde("pc_d", 1, 0, 1, 0);
    tick();
    drv(0, 0, 0, 1, 0, 5'b0);
    sfde("pc_e", 1, 0, 1, 0);
    tick();
    sfde("pc_m", 1, 0, 1, 0);
    tick();
    sfde("pc_w", 0, 0, 1, 0);
    tick();
    sfde("pc_done", 0, 0, 0, 0);
    idle(2);

    // same, with branch taken in the E cycle
    drv(0, 0, 1, 1, 0, 5'b0); tick();
    drv(0, 0, 0, 1, 1, 5'b0);
    sfde("br_e", 1, 0, 1, 1);
    tick();
    drv(0, 0, 0, 1, 0, 5'b0);
    chk("br_cnt", int'(br_cnt), 1);
    chk("br_cnt2", int'(br_cnt2), 1);
    idle(4);

    // load-use and branch in the same cycle
    drv(1, 1, 0, 1, 0, 5'b0); tick();
    drv(0, 0, 0, 1, 1, 5'b00001);
    sfde("ld_br", 1, 1, 1, 1);
    tick(); exp_ld++;
    drv(0, 0, 0, 1, 0, 5'b00001);
    chk("ld_br_clear", int'(sd), 0);
    chk("ld_br_brcnt", int'(br_cnt), 2);
    idle(3);

    // five more stalls: narrow counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      drv(1, 1, 0, 1, 0, 5'b0); tick();
      drv(0, 0, 0, 1, 0, 5'b00001);
      chk("sat_stall", int'(sd2), 1);
      tick(); exp_ld++;
    end
    drv(0, 0, 0, 0, 0, 5'b0);
    chk("sat_ld_wide", int'(ld_cnt), exp_ld);
    chk("sat_ld_narrow", int'(ld_cnt2), 3);
    idle(2);

    // reset in the middle of a stall
    drv(1, 1, 0, 1, 0, 5'b0); tick();
    drv(0, 0, 0, 1, 0, 5'b00001);
    chk("mid_stall_pre", int'(sd), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_stalld", int'(sd), 0);
    chk("mid_rst_stallf", int'(sf), 0);
    chk("mid_rst_ldcnt", int'(ld_cnt), 0);
    chk("mid_rst_brcnt", int'(br_cnt), 0);
    chk("mid_rst_ldcnt2", int'(ld_cnt2), 0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    sfde("post_rst", 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
